// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: byte-wide instruction memory port plus the execute-stage handshake.
// master = fetch unit, slave = memory/execute side.
interface fetch_unit_if;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic [7:0]  i_mem_data;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_inst_valid;
  logic        i_exec_ready;
  logic        i_pc_change;
  logic [31:0] i_new_pc;

  modport master (
    output o_mem_addr, o_mem_rd, o_inst, o_pc, o_inst_valid,
    input  i_mem_data, i_exec_ready, i_pc_change, i_new_pc
  );

  modport slave (
    input  o_mem_addr, o_mem_rd, o_inst, o_pc, o_inst_valid,
    output i_mem_data, i_exec_ready, i_pc_change, i_new_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles 32-bit little-endian words and holds them for execute.
// Optional one-word prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fetch_unit_if.master  bus
);
  // state   | meaning
  // S_FETCH | reading bytes of the word at r_fetch_pc, o_inst_valid=0
  // S_VALID | word held on o_inst/o_pc until execute accepts
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_VALID = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [1:0]  r_cnt;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  logic        w_accept;
  logic [31:0] w_seq_pc;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign w_accept = (r_state == S_VALID) && bus.i_exec_ready;
  assign w_seq_pc = r_pc + 32'd4;

  assign bus.o_inst       = r_valid ? r_inst : NOP_INST;
  assign bus.o_pc         = r_pc;
  assign bus.o_inst_valid = r_valid;

`ifdef FETCH_PREFETCH_EN
  logic [31:0] r_buf;
  logic [1:0]  r_bcnt;
  logic        r_bfull;
  logic [31:0] w_buf_merged;
  logic        w_buf_done;

  // A byte arriving on the accept edge is merged before the buffer is consumed.
  assign w_buf_merged = r_bfull ? r_buf : put_byte(r_buf, r_bcnt, bus.i_mem_data);
  assign w_buf_done   = r_bfull || (r_bcnt == 2'd3);
`else
  logic [31:0] w_next_pc;
  assign w_next_pc = bus.i_pc_change ? bus.i_new_pc : w_seq_pc;
`endif

  always_comb begin
    bus.o_mem_rd   = 1'b0;
    bus.o_mem_addr = 32'd0;
    if (r_state == S_FETCH) begin
      bus.o_mem_rd   = 1'b1;
      bus.o_mem_addr = r_fetch_pc + {30'd0, r_cnt};
    end
`ifdef FETCH_PREFETCH_EN
    else if (!r_bfull) begin
      bus.o_mem_rd   = 1'b1;
      bus.o_mem_addr = w_seq_pc + {30'd0, r_bcnt};
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_cnt      <= 2'd0;
      r_inst     <= 32'd0;
      r_pc       <= 32'd0;
      r_valid    <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      r_buf      <= 32'd0;
      r_bcnt     <= 2'd0;
      r_bfull    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          r_inst <= put_byte(r_inst, r_cnt, bus.i_mem_data);
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= S_VALID;
            r_valid <= 1'b1;
            r_pc    <= r_fetch_pc;
          end
        end
        default: begin
`ifdef FETCH_PREFETCH_EN
          if (w_accept && bus.i_pc_change) begin
            r_fetch_pc <= bus.i_new_pc;
            r_cnt      <= 2'd0;
            r_valid    <= 1'b0;
            r_state    <= S_FETCH;
            r_bfull    <= 1'b0;
            r_bcnt     <= 2'd0;
          end else if (w_accept) begin
            r_inst  <= w_buf_merged;
            r_bfull <= 1'b0;
            r_bcnt  <= 2'd0;
            if (w_buf_done) begin
              r_pc <= w_seq_pc;
            end else begin
              // Partial buffer: continue the same word in FETCH from the next byte.
              r_fetch_pc <= w_seq_pc;
              r_cnt      <= r_bcnt + 2'd1;
              r_valid    <= 1'b0;
              r_state    <= S_FETCH;
            end
          end else if (!r_bfull) begin
            r_buf  <= w_buf_merged;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) r_bfull <= 1'b1;
          end
`else
          if (w_accept) begin
            r_fetch_pc <= w_next_pc;
            r_valid    <= 1'b0;
            r_state    <= S_FETCH;
          end
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses and
// instructions, a negedge monitor pops and compares them as the DUT presents them.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0100), .NOP_INST(NOP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] q_addr[$];
  logic [63:0] q_inst[$];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  assign bus.i_mem_data = mem_byte(bus.o_mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic        last_valid = 1'b0;
  logic [31:0] last_pc = 32'd0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.o_mem_rd) begin
        if (q_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got addr %h expected no fetch", bus.o_mem_addr);
        end else begin
          check("mem_addr", bus.o_mem_addr, q_addr.pop_front());
        end
      end else begin
        check("idle_addr", bus.o_mem_addr, 32'd0);
      end
      if (!bus.o_inst_valid) begin
        check("nop_inst", bus.o_inst, NOP);
      end else if (!last_valid || bus.o_pc != last_pc) begin
        if (q_inst.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got pc %h expected no instruction", bus.o_pc);
        end else begin
          logic [63:0] e;
          e = q_inst.pop_front();
          check("inst_pc", bus.o_pc, e[63:32]);
          check("inst_word", bus.o_inst, e[31:0]);
        end
      end
      last_valid <= bus.o_inst_valid;
      last_pc    <= bus.o_pc;
    end else begin
      last_valid <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.o_inst_valid && n < 20) begin
      tick();
      n++;
    end
    check("wait_valid", {31'd0, bus.o_inst_valid}, 32'd1);
  endtask

  task automatic push_fetch(input logic [31:0] pc, input logic [31:0] inst);
    for (int i = 0; i < 4; i++) q_addr.push_back(pc + i);
    q_inst.push_back({pc, inst});
  endtask

  task automatic accept(input logic chg, input logic [31:0] target);
    bus.i_exec_ready = 1'b1;
    bus.i_pc_change  = chg;
    bus.i_new_pc     = chg ? target : 32'hDEAD_BEEF;
    tick();
    bus.i_exec_ready = 1'b0;
    bus.i_pc_change  = 1'b0;
    bus.i_new_pc     = 32'h0;
    check("valid_after_accept", {31'd0, bus.o_inst_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.i_exec_ready = 1'b0;
    bus.i_pc_change  = 1'b0;
    bus.i_new_pc     = 32'h0;
    repeat (3) tick();
    check("rst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
    check("rst_inst", bus.o_inst, NOP);
    check("rst_pc", bus.o_pc, 32'd0);
    check("rst_addr", bus.o_mem_addr, 32'h100);

    push_fetch(32'h100, 32'h0010_0513);
`ifdef FETCH_PREFETCH_EN
    push_fetch(32'h104, word_at(32'h104));
    rst_n = 1'b1;
    wait_valid();
    repeat (6) tick();
    check("pf_full_rd", {31'd0, bus.o_mem_rd}, 32'd0);
    check("pf_hold_pc", bus.o_pc, 32'h100);
    bus.i_exec_ready = 1'b1;
    tick();
    bus.i_exec_ready = 1'b0;
    check("pf_stay_valid", {31'd0, bus.o_inst_valid}, 32'd1);
    check("pf_pc", bus.o_pc, 32'h104);
    q_addr.push_back(32'h108);
    push_fetch(32'h300, word_at(32'h300));
    accept(1'b1, 32'h300);
    wait_valid();
`else
    rst_n = 1'b1;
    wait_valid();

    for (int i = 0; i < 10; i++) begin
      bus.i_pc_change = i[0];
      bus.i_new_pc    = $urandom;
      tick();
      check("hold_pc", bus.o_pc, 32'h100);
      check("hold_inst", bus.o_inst, 32'h0010_0513);
      check("hold_rd", {31'd0, bus.o_mem_rd}, 32'd0);
    end
    bus.i_pc_change = 1'b0;

    push_fetch(32'h104, word_at(32'h104));
    accept(1'b0, 32'h0);
    wait_valid();
    check("seq_pc", bus.o_pc, 32'h104);

    push_fetch(32'h200, word_at(32'h200));
    accept(1'b1, 32'h200);
    wait_valid();
    push_fetch(32'hFFFF_FFFE, word_at(32'hFFFF_FFFE));
    accept(1'b1, 32'hFFFF_FFFE);
    wait_valid();
    push_fetch(32'hFFFF_FFFC, word_at(32'hFFFF_FFFC));
    accept(1'b1, 32'hFFFF_FFFC);
    wait_valid();
    push_fetch(32'h0, word_at(32'h0));
    accept(1'b0, 32'h0);
    wait_valid();
    check("wrap_pc", bus.o_pc, 32'h0);

    // Reset in the middle of fetching 0x104
    q_addr.push_back(32'h104);
    q_addr.push_back(32'h105);
    accept(1'b1, 32'h104);
    tick();
    tick();
    check("byte2_addr", bus.o_mem_addr, 32'h106);
    rst_n = 1'b0;
    tick();
    check("midrst_addr", bus.o_mem_addr, 32'h100);
    check("midrst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
    check("midrst_inst", bus.o_inst, NOP);
    check("midrst_pc", bus.o_pc, 32'd0);
    push_fetch(32'h100, 32'h0010_0513);
    rst_n = 1'b1;
    wait_valid();
`endif
    repeat (3) tick();
    check("addr_queue_empty", q_addr.size(), 32'd0);
    check("inst_queue_empty", q_inst.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
